// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct codes seen by the decoder/ALU and the FSM state encoding.
package alu_muldiv_seq_pkg;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_seq_muldiv_step.sv
// One iteration on {acc, q}: LSB-first shift-add for multiply,
// restoring shift-subtract for divide. Operands are magnitudes.
module muldiv_step #(
    parameter int NB_DATA = 32
) (
    input  logic               i_is_div,
    input  logic [NB_DATA-1:0] i_acc,
    input  logic [NB_DATA-1:0] i_q,
    input  logic [NB_DATA-1:0] i_b,
    output logic [NB_DATA-1:0] o_acc,
    output logic [NB_DATA-1:0] o_q
);

    logic [NB_DATA:0] w_sum;
    logic [NB_DATA:0] w_sh;
    logic [NB_DATA:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
        w_sh   = {i_acc, i_q[NB_DATA-1]};
        w_diff = w_sh - {1'b0, i_b};
        o_acc  = '0;
        o_q    = '0;
        if (i_is_div) begin
            // borrow out means the trial subtract failed: restore
            if (w_diff[NB_DATA]) begin
                o_acc = w_sh[NB_DATA-1:0];
                o_q   = {i_q[NB_DATA-2:0], 1'b0};
            end else begin
                o_acc = w_diff[NB_DATA-1:0];
                o_q   = {i_q[NB_DATA-2:0], 1'b1};
            end
        end else begin
            o_acc = w_sum[NB_DATA:1];
            o_q   = {w_sum[0], i_q[NB_DATA-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO,
// plus single-cycle MTHI/MTLO. Busy is signalled by o_ready low.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic               o_ready,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

    state_t r_state;
    state_t w_next;

    logic [NB_DATA-1:0]   r_acc;
    logic [NB_DATA-1:0]   r_q;
    logic [NB_DATA-1:0]   r_b;
    logic [NB_CNT-1:0]    r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div0;
    logic                 r_done;
    logic [NB_DATA-1:0]   r_hi;
    logic [NB_DATA-1:0]   r_lo;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_signed;
    logic                 w_div_op;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [NB_DATA-1:0]   w_a_mag;
    logic [NB_DATA-1:0]   w_b_mag;
    logic [NB_DATA-1:0]   w_step_acc;
    logic [NB_DATA-1:0]   w_step_q;
    logic [NB_DATA-1:0]   w_quo;
    logic [NB_DATA-1:0]   w_rem;
    logic [2*NB_DATA-1:0] w_prod;

    assign w_accept = i_valid & o_ready;

    always_comb begin
        w_start  = 1'b0;
        w_signed = 1'b0;
        w_div_op = 1'b0;
        case (i_op)
            F_MULT: begin
                w_start  = 1'b1;
                w_signed = 1'b1;
            end
            F_MULTU: w_start = 1'b1;
            F_DIV: begin
                w_start  = 1'b1;
                w_signed = 1'b1;
                w_div_op = 1'b1;
            end
            F_DIVU: begin
                w_start  = 1'b1;
                w_div_op = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_a_neg = w_signed & i_data_a[NB_DATA-1];
    assign w_b_neg = w_signed & i_data_b[NB_DATA-1];
    assign w_a_mag = w_a_neg ? -i_data_a : i_data_a;
    assign w_b_mag = w_b_neg ? -i_data_b : i_data_b;

    muldiv_step #(
        .NB_DATA (NB_DATA)
    ) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_b      (r_b),
        .o_acc    (w_step_acc),
        .o_q      (w_step_q)
    );

    assign w_prod = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
    assign w_quo  = r_neg_q ? -r_q : r_q;
    assign w_rem  = r_neg_r ? -r_acc : r_acc;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_start) w_next = S_CALC;
            S_CALC:  if (r_cnt == CNT_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    if (w_start) begin
                        r_acc    <= '0;
                        r_q      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_cnt    <= '0;
                        r_is_div <= w_div_op;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div0   <= (i_data_b == '0);
                    end else if (i_op == F_MTHI) begin
                        r_hi <= i_data_a;
                    end else if (i_op == F_MTLO) begin
                        r_lo <= i_data_a;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step_acc;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    // divide by zero: remainder already equals the dividend
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= r_div0 ? '1 : w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: expected HI/LO are queued
// at issue and compared whenever the unit pulses o_done.
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    alu_muldiv_seq #(
        .NB_DATA (32),
        .NB_OP   (6)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_valid  (valid),
        .i_op     (op),
        .i_data_a (a),
        .i_data_b (b),
        .o_ready  (ready),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] o,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t   r;
        longint p;
        int     xs;
        int     ys;
        logic [63:0] u;
        xs = $signed(x);
        ys = $signed(y);
        r.hi = '0;
        r.lo = '0;
        if (o == F_MULT) begin
            p = longint'(xs) * longint'(ys);
            {r.hi, r.lo} = p;
        end else if (o == F_MULTU) begin
            u = {32'b0, x} * {32'b0, y};
            {r.hi, r.lo} = u;
        end else if (y == 0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = x;
        end else if (o == F_DIV) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                r.lo = 32'h8000_0000;
                r.hi = 32'h0;
            end else begin
                r.lo = xs / ys;
                r.hi = xs % ys;
            end
        end else begin
            r.lo = x / y;
            r.hi = x % y;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("hilo", {hi, lo}, {e.hi, e.lo});
            end
        end
    end

    // called at a negedge with the unit idle
    task automatic run_md(input string tag, input logic [5:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        check({tag, "_rdy_in"}, {63'b0, ready}, 64'd1);
        valid = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb_q.push_back('{eh, el});
        @(negedge clk);
        valid = 1'b0;
        cyc   = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd33);
        check({tag, "_rdy_done"}, {63'b0, ready}, 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n_done;
        rst   = 1'b1;
        valid = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_rdy", {63'b0, ready}, 64'd1);
        check("rst_done", {63'b0, done}, 64'd0);

        run_md("mult", F_MULT, 32'hFFFF_FFFB, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFDD);
        run_md("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2,
               32'h0000_0001, 32'hFFFF_FFFE);
        run_md("div", F_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_md("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0, 32'h8000_0000);
        run_md("divu_z", F_DIVU, 32'h1234, 32'h0,
               32'h0000_1234, 32'hFFFF_FFFF);
        run_md("div_z", F_DIV, 32'hFFFF_FF00, 32'h0,
               32'hFFFF_FF00, 32'hFFFF_FFFF);

        // busy: a MULT at cycle 10 of a DIV must be dropped
        check("busy_rdy_in", {63'b0, ready}, 64'd1);
        valid = 1'b1;
        op    = F_DIV;
        a     = 32'd100;
        b     = 32'd7;
        sb_q.push_back('{32'd2, 32'd14});
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_rdy", {63'b0, ready}, 64'd0);
        valid = 1'b1;
        op    = F_MULT;
        a     = 32'd3;
        b     = 32'd3;
        @(negedge clk);
        valid = 1'b0;
        cyc   = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_done", {63'b0, done}, 64'd1);

        // MTLO in the o_done cycle
        valid = 1'b1;
        op    = F_MTLO;
        a     = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        check("mtlo_lo", 64'(lo), 64'h0000_ABCD);
        check("mtlo_hi", 64'(hi), 64'd2);
        check("mtlo_rdy", {63'b0, ready}, 64'd1);
        @(negedge clk);
        op = F_MTHI;
        a  = 32'h0000_5555;
        @(negedge clk);
        valid = 1'b0;
        check("mthi_hilo", {hi, lo}, 64'h0000_5555_0000_ABCD);
        check("mthi_rdy", {63'b0, ready}, 64'd1);

        // unknown funct is ignored
        valid = 1'b1;
        op    = 6'b100000;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1;
        @(negedge clk);
        valid = 1'b0;
        check("unk_rdy", {63'b0, ready}, 64'd1);
        repeat (3) @(negedge clk);
        check("unk_hilo", {hi, lo}, 64'h0000_5555_0000_ABCD);
        check("unk_rdy2", {63'b0, ready}, 64'd1);

        for (int i = 0; i < 10; i++) begin
            logic [5:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            exp_t        e;
            o = F_MULT + 6'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if (i == 3) y = 32'h0;
            if (i >= 6) y = $urandom_range(1, 40);
            if (i == 8) y = 32'hFFFF_FFF3;
            e = model(o, x, y);
            run_md($sformatf("rand%0d", i), o, x, y, e.hi, e.lo);
        end

        // reset at cycle 15 of a MULT aborts it
        valid = 1'b1;
        op    = F_MULT;
        a     = 32'd3;
        b     = 32'd4;
        @(negedge clk);
        valid = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_hilo", {hi, lo}, 64'd0);
        check("rstmid_rdy", {63'b0, ready}, 64'd1);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rstmid_nodone", 64'(n_done), 64'd0);
        check("rstmid_hilo2", {hi, lo}, 64'd0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
